// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and the write-request record used by the register-file
// write arbiter and its scoreboard.
package rf_pkg;

    localparam int REG_AW    = 5;
    localparam int NUM_REGS  = 32;
    localparam int RF_DATA_W = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic                 we;
        logic [REG_AW-1:0]    wa;
        logic [RF_DATA_W-1:0] wd;
    } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus bundle between writeback/long-latency sources, the hazard unit and the
// register-file write port.
interface rf_write_arbiter_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W
) ();

    logic              a_we;
    logic [REG_AW-1:0] a_wa;
    logic [DATA_W-1:0] a_wd;
    logic              b_valid;
    logic [REG_AW-1:0] b_wa;
    logic [DATA_W-1:0] b_wd;
    logic              b_ready;
    logic              mark_valid;
    logic [REG_AW-1:0] mark_addr;
    logic [REG_AW-1:0] q_ra1;
    logic [REG_AW-1:0] q_ra2;
    logic              busy1;
    logic              busy2;
    logic              rf_we;
    logic [REG_AW-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic              stall_req;
    logic              waw_err;

    modport master (
        output a_we, a_wa, a_wd,
        output b_valid, b_wa, b_wd,
        input  b_ready,
        output mark_valid, mark_addr,
        output q_ra1, q_ra2,
        input  busy1, busy2,
        input  rf_we, rf_wa, rf_wd,
        input  stall_req, waw_err
    );

    modport slave (
        input  a_we, a_wa, a_wd,
        input  b_valid, b_wa, b_wd,
        output b_ready,
        input  mark_valid, mark_addr,
        input  q_ra1, q_ra2,
        output busy1, busy2,
        output rf_we, rf_wa, rf_wd,
        output stall_req, waw_err
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Busy bit per architectural register: set on long-latency issue, cleared
// when that result commits. Reads reflect the state before this cycle's update.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_addr,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_addr,
    input  logic [REG_AW-1:0]   q_ra1,
    input  logic [REG_AW-1:0]   q_ra2,
    output logic                busy1,
    output logic                busy2,
    output logic [NUM_REGS-1:0] busy
);

    logic [NUM_REGS-1:0] busy_nxt;

    // Set is applied after clear so a fresh issue survives a same-cycle commit.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_addr] = 1'b0;
        if (set_en && (set_addr != REG_ZERO))
            busy_nxt[set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    assign busy1 = (q_ra1 != REG_ZERO) && busy[q_ra1];
    assign busy2 = (q_ra2 != REG_ZERO) && busy[q_ra2];

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between in-order writeback (A, highest
// priority) and the long-latency return path (B, one-entry skid buffer).
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W       = RF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rf_write_arbiter_if.slave  bus
);

    wr_req_t             a_req;
    wr_req_t             b_req;
    wr_req_t             buf_req_p0;
    wr_req_t             sel_req;
    logic                buf_valid;
    logic                b_ready;
    logic                b_fire;
    logic                capture;
    logic                bypass;
    logic                drain;
    logic                commit_en;
    logic [REG_AW-1:0]   commit_wa;
    logic [3:0]          starve_cnt;
    logic [3:0]          starve_nxt;
    logic                stall_q;
    logic                waw_q;
    logic [NUM_REGS-1:0] busy_vec;

    assign a_req = '{we: bus.a_we,    wa: bus.a_wa, wd: RF_DATA_W'(bus.a_wd)};
    assign b_req = '{we: bus.b_valid, wa: bus.b_wa, wd: RF_DATA_W'(bus.b_wd)};

    // A full buffer refuses B even while it drains, keeping b_ready off the drain path.
    assign b_ready = !buf_valid && rst_n;
    assign b_fire  = bus.b_valid && b_ready;
    assign capture = b_fire && bus.a_we;
    assign bypass  = b_fire && !bus.a_we;
    assign drain   = buf_valid && !bus.a_we;

    assign commit_en = bypass || drain;
    assign commit_wa = drain ? buf_req_p0.wa : bus.b_wa;

    always_comb begin
        sel_req = '0;
        if (a_req.we)
            sel_req = a_req;
        else if (buf_valid)
            sel_req = buf_req_p0;
        else if (bus.b_valid)
            sel_req = b_req;
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (drain)
            starve_nxt = 4'd0;
        else if (buf_valid && bus.a_we && (starve_cnt != 4'hf))
            starve_nxt = starve_cnt + 4'd1;
    end

    // Skid buffer stage: control is reset, the held payload is not.
    always_ff @(posedge clk) begin
        if (!rst_n)
            buf_valid <= 1'b0;
        else if (capture)
            buf_valid <= 1'b1;
        else if (drain)
            buf_valid <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (capture)
            buf_req_p0 <= b_req;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= 4'd0;
            stall_q    <= 1'b0;
            waw_q      <= 1'b0;
        end else begin
            starve_cnt <= starve_nxt;
            if (drain)
                stall_q <= 1'b0;
            else if (starve_nxt >= 4'(STARVE_LIMIT))
                stall_q <= 1'b1;
            if (bus.a_we && (bus.a_wa != REG_ZERO) && busy_vec[bus.a_wa])
                waw_q <= 1'b1;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (bus.mark_valid),
        .set_addr (bus.mark_addr),
        .clr_en   (commit_en),
        .clr_addr (commit_wa),
        .q_ra1    (bus.q_ra1),
        .q_ra2    (bus.q_ra2),
        .busy1    (bus.busy1),
        .busy2    (bus.busy2),
        .busy     (busy_vec)
    );

    assign bus.b_ready   = b_ready;
    assign bus.rf_we     = sel_req.we && (sel_req.wa != REG_ZERO) && rst_n;
    assign bus.rf_wa     = sel_req.wa;
    assign bus.rf_wd     = DATA_W'(sel_req.wd);
    assign bus.stall_req = stall_q;
    assign bus.waw_err   = waw_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based model of the arbiter's rules.
module tb_rf_write_arbiter;

    localparam int LIMIT = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rf_write_arbiter_if #(.DATA_W(32)) bus ();

    rf_write_arbiter #(.DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    bit [31:0]   m_busy;
    logic [4:0]  mq_wa[$];
    logic [31:0] mq_wd[$];
    int          m_starve;
    bit          m_stall;
    bit          m_waw;
    bit          m_known;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit r, input bit awe, input logic [4:0] awa, input logic [31:0] awd,
                       input bit bv, input logic [4:0] bwa, input logic [31:0] bwd,
                       input bit mv, input logic [4:0] ma, input logic [4:0] q1, input logic [4:0] q2);
        rst_n          = r;
        bus.a_we       = awe;
        bus.a_wa       = awa;
        bus.a_wd       = awd;
        bus.b_valid    = bv;
        bus.b_wa       = bwa;
        bus.b_wd       = bwd;
        bus.mark_valid = mv;
        bus.mark_addr  = ma;
        bus.q_ra1      = q1;
        bus.q_ra2      = q2;
    endtask

    task automatic idle(input logic [4:0] q1);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, q1, 0);
    endtask

    task automatic model_edge();
        bit         commit;
        logic [4:0] cwa;
        commit = 0;
        cwa    = 0;
        if (!rst_n) begin
            m_busy   = '0;
            mq_wa.delete();
            mq_wd.delete();
            m_starve = 0;
            m_stall  = 0;
            m_waw    = 0;
            m_known  = 1;
            return;
        end
        if (bus.a_we && bus.a_wa != 0 && m_busy[bus.a_wa])
            m_waw = 1;
        if (mq_wa.size() != 0) begin
            if (bus.a_we) begin
                m_starve = (m_starve < 15) ? m_starve + 1 : 15;
                if (m_starve >= LIMIT)
                    m_stall = 1;
            end else begin
                cwa = mq_wa.pop_front();
                void'(mq_wd.pop_front());
                commit   = 1;
                m_starve = 0;
                m_stall  = 0;
            end
        end else if (bus.b_valid) begin
            if (bus.a_we) begin
                mq_wa.push_back(bus.b_wa);
                mq_wd.push_back(bus.b_wd);
            end else begin
                commit = 1;
                cwa    = bus.b_wa;
            end
        end
        if (commit)
            m_busy[cwa] = 0;
        if (bus.mark_valid && bus.mark_addr != 0)
            m_busy[bus.mark_addr] = 1;
    endtask

    // Checks the combinational view before the edge, then advances one cycle.
    task automatic tick();
        bit          e_br;
        bit          e_sel;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        #1;
        if (m_known && m_stall && bus.a_we) begin
            errors++;
            $error("FAIL protocol a_we=1 while stall_req model=1");
        end
        e_br  = rst_n && (mq_wa.size() == 0);
        e_sel = 0;
        e_wa  = 0;
        e_wd  = 0;
        if (bus.a_we) begin
            e_sel = 1; e_wa = bus.a_wa; e_wd = bus.a_wd;
        end else if (mq_wa.size() != 0) begin
            e_sel = 1; e_wa = mq_wa[0]; e_wd = mq_wd[0];
        end else if (bus.b_valid) begin
            e_sel = 1; e_wa = bus.b_wa; e_wd = bus.b_wd;
        end
        if (!rst_n || !m_known) begin
            chk("rst_rf_we", bus.rf_we, 0);
            chk("rst_b_ready", bus.b_ready, 0);
        end else begin
            chk("b_ready", bus.b_ready, e_br);
            chk("rf_we", bus.rf_we, e_sel && e_wa != 0);
            if (!e_sel || e_wa != 0) begin
                chk("rf_wa", bus.rf_wa, e_wa);
                chk("rf_wd", bus.rf_wd, e_wd);
            end
            chk("busy1", bus.busy1, bus.q_ra1 != 0 && m_busy[bus.q_ra1]);
            chk("busy2", bus.busy2, bus.q_ra2 != 0 && m_busy[bus.q_ra2]);
            chk("stall_req", bus.stall_req, m_stall);
            chk("waw_err", bus.waw_err, m_waw);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks  = 0;
        errors  = 0;
        m_busy  = '0;
        m_starve = 0;
        m_stall = 0;
        m_waw   = 0;
        m_known = 0;

        // Power-up reset
        drv(0, 0, 0, 0, 1, 3, 32'h5, 0, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle(0);
        #1;
        chk("post_rst_stall", bus.stall_req, 0);
        chk("post_rst_waw", bus.waw_err, 0);
        chk("post_rst_b_ready", bus.b_ready, 1);
        tick();

        // B bypass clears an outstanding busy bit
        drv(1, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        tick();
        drv(1, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0);
        #1;
        chk("byp_b_ready", bus.b_ready, 1);
        chk("byp_rf_we", bus.rf_we, 1);
        chk("byp_rf_wa", bus.rf_wa, 7);
        chk("byp_rf_wd", bus.rf_wd, 32'h1234);
        chk("byp_busy_same_cycle", bus.busy1, 1);
        tick();
        idle(7);
        #1;
        chk("byp_busy_after", bus.busy1, 0);
        tick();

        // Collision: A wins, B is buffered and drains next cycle
        drv(1, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
        #1;
        chk("col0_rf_wa", bus.rf_wa, 3);
        chk("col0_rf_wd", bus.rf_wd, 32'h11);
        chk("col0_b_ready", bus.b_ready, 1);
        tick();
        idle(0);
        #1;
        chk("col1_b_ready", bus.b_ready, 0);
        chk("col1_rf_we", bus.rf_we, 1);
        chk("col1_rf_wa", bus.rf_wa, 4);
        chk("col1_rf_wd", bus.rf_wd, 32'h22);
        tick();
        idle(0);
        #1;
        chk("col2_b_ready", bus.b_ready, 1);
        tick();

        // Starvation: four blocked cycles raise stall_req
        drv(1, 1, 1, 32'h1, 1, 2, 32'h2, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < LIMIT; i++) begin
            drv(1, 1, 1, 32'h100 + i, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("starve_no_stall", bus.stall_req, 0);
            tick();
        end
        idle(0);
        #1;
        chk("starve_stall", bus.stall_req, 1);
        chk("starve_drain_wa", bus.rf_wa, 2);
        chk("starve_drain_wd", bus.rf_wd, 32'h2);
        tick();
        idle(0);
        #1;
        chk("starve_stall_clear", bus.stall_req, 0);
        tick();

        // Reset mid-operation with a buffered B, busy bit and stall pending
        drv(1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        tick();
        drv(1, 1, 1, 32'h7, 1, 5, 32'hAA, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < LIMIT; i++) begin
            drv(1, 1, 1, 32'h200 + i, 0, 0, 0, 0, 0, 5, 0);
            tick();
        end
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        #1;
        chk("midrst_rf_we", bus.rf_we, 0);
        chk("midrst_b_ready", bus.b_ready, 0);
        tick();
        idle(5);
        #1;
        chk("midrst_stall", bus.stall_req, 0);
        chk("midrst_busy5", bus.busy1, 0);
        chk("midrst_no_buf_write", bus.rf_we, 0);
        chk("midrst_b_ready_after", bus.b_ready, 1);
        tick();

        // Scoreboard: same-cycle mark and commit of r9, and mark of r0
        drv(1, 0, 0, 0, 1, 9, 32'h99, 1, 9, 0, 0);
        tick();
        idle(9);
        #1;
        chk("sb_set_wins", bus.busy1, 1);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        #1;
        chk("sb_r0_query", bus.busy1, 0);
        chk("sb_r9_still", bus.busy2, 1);
        tick();

        // r0 write is consumed but never reaches the RF
        drv(1, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0, 0, 0);
        #1;
        chk("r0_b_ready", bus.b_ready, 1);
        chk("r0_rf_we", bus.rf_we, 0);
        tick();

        // WAW: A writes r9 while it is busy
        drv(1, 1, 9, 32'h3, 0, 0, 0, 0, 0, 9, 0);
        #1;
        chk("waw_before", bus.waw_err, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(0);
            #1;
            chk("waw_sticky", bus.waw_err, 1);
            tick();
        end

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit r;
            bit awe;
            r   = ($urandom_range(0, 99) >= 2);
            awe = m_stall ? 1'b0 : ($urandom_range(0, 9) < 6);
            drv(r, awe, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            tick();
        end

        // Final reset clears the sticky error
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        idle(0);
        #1;
        chk("final_waw_clear", bus.waw_err, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
